// File: rtl/conv_pass_scheduler_pkg.sv
// Shared types and defaults for the convolution pass scheduler.
// Holds the FSM state encoding and the default sizing used by the top and watchdog.
package conv_pass_scheduler_pkg;

    localparam int unsigned DefaultAddrWidth     = 16;
    localparam int unsigned DefaultPassWidth     = 8;
    localparam int unsigned DefaultTimeoutCycles = 4096;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StSetup  = 3'd1,
        StRun    = 3'd2,
        StDrain  = 3'd3,
        StFinish = 3'd4
    } state_e;

    // Counter width for a watchdog that must distinguish TIMEOUT_CYCLES distinct values.
    function automatic int unsigned wd_width(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/conv_pass_scheduler_watchdog.sv
// Per-pass watchdog: counts enabled cycles from a clear and flags the cycle on which
// the budget of TIMEOUT_CYCLES is used up.
module conv_pass_scheduler_watchdog
    import conv_pass_scheduler_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CntWidth = wd_width(TIMEOUT_CYCLES);
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(TIMEOUT_CYCLES - 1);

    logic [CntWidth-1:0] cnt_q;
    logic [CntWidth-1:0] cnt_d;

    assign expired = enable && (cnt_q == CntLast);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + CntWidth'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/conv_pass_scheduler.sv
// Multi-pass convolution sequencer: per pass presents buffer bases, holds conv_en until
// the engine finishes, then steps each base by its stride. Busy/done, abort and watchdog.
module conv_pass_scheduler
    import conv_pass_scheduler_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = DefaultAddrWidth,
    parameter int unsigned PASS_WIDTH     = DefaultPassWidth,
    parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic                  abort,
    input  logic [PASS_WIDTH-1:0] num_passes,
    input  logic [ADDR_WIDTH-1:0] in_stride,
    input  logic [ADDR_WIDTH-1:0] w_stride,
    input  logic [ADDR_WIDTH-1:0] r_stride,
    input  logic                  conv_done,
    output logic                  conv_en,
    output logic [ADDR_WIDTH-1:0] in_base,
    output logic [ADDR_WIDTH-1:0] w_base,
    output logic [ADDR_WIDTH-1:0] r_base,
    output logic [PASS_WIDTH-1:0] pass_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err
);

    state_e state_q, state_d;

    logic [PASS_WIDTH-1:0] num_q, num_d;
    logic [ADDR_WIDTH-1:0] in_stride_q, in_stride_d;
    logic [ADDR_WIDTH-1:0] w_stride_q, w_stride_d;
    logic [ADDR_WIDTH-1:0] r_stride_q, r_stride_d;
    logic [ADDR_WIDTH-1:0] in_base_q, in_base_d;
    logic [ADDR_WIDTH-1:0] w_base_q, w_base_d;
    logic [ADDR_WIDTH-1:0] r_base_q, r_base_d;
    logic [PASS_WIDTH-1:0] pass_idx_q, pass_idx_d;
    logic                  conv_en_q, conv_en_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  timeout_err_q, timeout_err_d;

    logic wd_expired;
    logic last_pass;

    conv_pass_scheduler_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rstn    (rstn),
        .clear   (state_q != StRun),
        .enable  (state_q == StRun),
        .expired (wd_expired)
    );

    assign last_pass = (pass_idx_q == num_q - PASS_WIDTH'(1));

    always_comb begin
        state_d       = state_q;
        num_d         = num_q;
        in_stride_d   = in_stride_q;
        w_stride_d    = w_stride_q;
        r_stride_d    = r_stride_q;
        in_base_d     = in_base_q;
        w_base_d      = w_base_q;
        r_base_d      = r_base_q;
        pass_idx_d    = pass_idx_q;
        conv_en_d     = conv_en_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        timeout_err_d = timeout_err_q;

        if (abort) begin
            // Abort beats everything, including a simultaneous start in IDLE.
            state_d   = StIdle;
            conv_en_d = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        num_d         = num_passes;
                        in_stride_d   = in_stride;
                        w_stride_d    = w_stride;
                        r_stride_d    = r_stride;
                        in_base_d     = '0;
                        w_base_d      = '0;
                        r_base_d      = '0;
                        pass_idx_d    = '0;
                        timeout_err_d = 1'b0;
                        busy_d        = 1'b1;
                        state_d       = (num_passes == '0) ? StFinish : StSetup;
                    end
                end
                StSetup: begin
                    conv_en_d = 1'b1;
                    state_d   = StRun;
                end
                StRun: begin
                    if (conv_done) begin
                        conv_en_d = 1'b0;
                        state_d   = StDrain;
                    end else if (wd_expired) begin
                        conv_en_d     = 1'b0;
                        timeout_err_d = 1'b1;
                        busy_d        = 1'b0;
                        state_d       = StIdle;
                    end
                end
                StDrain: begin
                    // Level-style engines keep conv_done up until they see conv_en low.
                    if (!conv_done) begin
                        if (last_pass) begin
                            state_d = StFinish;
                        end else begin
                            pass_idx_d = pass_idx_q + PASS_WIDTH'(1);
                            in_base_d  = in_base_q + in_stride_q;
                            w_base_d   = w_base_q + w_stride_q;
                            r_base_d   = r_base_q + r_stride_q;
                            state_d    = StSetup;
                        end
                    end
                end
                StFinish: begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
                default: begin
                    state_d   = StIdle;
                    conv_en_d = 1'b0;
                    busy_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= StIdle;
            num_q         <= '0;
            in_stride_q   <= '0;
            w_stride_q    <= '0;
            r_stride_q    <= '0;
            in_base_q     <= '0;
            w_base_q      <= '0;
            r_base_q      <= '0;
            pass_idx_q    <= '0;
            conv_en_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            num_q         <= num_d;
            in_stride_q   <= in_stride_d;
            w_stride_q    <= w_stride_d;
            r_stride_q    <= r_stride_d;
            in_base_q     <= in_base_d;
            w_base_q      <= w_base_d;
            r_base_q      <= r_base_d;
            pass_idx_q    <= pass_idx_d;
            conv_en_q     <= conv_en_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign conv_en     = conv_en_q;
    assign in_base     = in_base_q;
    assign w_base      = w_base_q;
    assign r_base      = r_base_q;
    assign pass_idx    = pass_idx_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = timeout_err_q;

    a_en_only_in_run : assert property (@(posedge clk) disable iff (!rstn)
        conv_en_q == (state_q == StRun));
    a_bases_stable : assert property (@(posedge clk) disable iff (!rstn)
        (conv_en_q && $past(conv_en_q)) |-> ($stable(in_base_q) && $stable(w_base_q)
                                              && $stable(r_base_q)));
    a_done_not_busy : assert property (@(posedge clk) disable iff (!rstn)
        done_q |-> !busy_q);

endmodule

// File: tb/tb_conv_pass_scheduler.sv
// Directed bench for conv_pass_scheduler with a small conv-engine model (pulse or level done).
// A second instance with a short watchdog budget exercises the timeout path.
module tb_conv_pass_scheduler;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  num_passes = '0;
    logic [15:0] in_stride = '0, w_stride = '0, r_stride = '0;
    logic        conv_done = 1'b0;
    logic        conv_en, busy, done, timeout_err;
    logic [15:0] in_base, w_base, r_base;
    logic [7:0]  pass_idx;

    logic        start_wd = 1'b0, abort_wd = 1'b0, conv_done_wd = 1'b0;
    logic        conv_en_wd, busy_wd, done_wd, timeout_err_wd;
    logic [15:0] in_base_wd, w_base_wd, r_base_wd;
    logic [7:0]  pass_idx_wd;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    conv_pass_scheduler dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort), .num_passes(num_passes),
        .in_stride(in_stride), .w_stride(w_stride), .r_stride(r_stride),
        .conv_done(conv_done), .conv_en(conv_en), .in_base(in_base), .w_base(w_base),
        .r_base(r_base), .pass_idx(pass_idx), .busy(busy), .done(done),
        .timeout_err(timeout_err)
    );

    conv_pass_scheduler #(.TIMEOUT_CYCLES(16)) dut_wd (
        .clk(clk), .rstn(rstn), .start(start_wd), .abort(abort_wd), .num_passes(num_passes),
        .in_stride(in_stride), .w_stride(w_stride), .r_stride(r_stride),
        .conv_done(conv_done_wd), .conv_en(conv_en_wd), .in_base(in_base_wd),
        .w_base(w_base_wd), .r_base(r_base_wd), .pass_idx(pass_idx_wd), .busy(busy_wd),
        .done(done_wd), .timeout_err(timeout_err_wd)
    );

    // Engine model: done N cycles after conv_en rise; level mode holds it a few cycles more.
    int eng_delay = 1000;
    bit eng_level = 1'b0;
    int eng_hold  = 0;
    int eng_cnt   = 0;
    int eng_left  = 0;

    always @(posedge clk) begin
        #1;
        if (conv_en) begin
            eng_cnt  = eng_cnt + 1;
            eng_left = eng_hold;
            if (eng_level) conv_done = (eng_cnt >= eng_delay);
            else           conv_done = (eng_cnt == eng_delay);
        end else begin
            eng_cnt = 0;
            if (eng_level && conv_done && eng_left > 0) eng_left = eng_left - 1;
            else conv_done = 1'b0;
        end
    end

    logic [15:0] win_in[64], win_w[64], win_r[64];
    logic [7:0]  win_p[64];
    int win_cnt = 0, done_cnt = 0, done_wd_cnt = 0;
    int gap_bad = 0, base_chg = 0, done_busy_bad = 0, gap_len = 100;
    logic en_prev = 1'b0;
    logic [15:0] cur_in, cur_w, cur_r;

    always @(negedge clk) begin
        if (conv_en && !en_prev) begin
            if (win_cnt < 64) begin
                win_in[win_cnt] = in_base;
                win_w[win_cnt]  = w_base;
                win_r[win_cnt]  = r_base;
                win_p[win_cnt]  = pass_idx;
            end
            win_cnt = win_cnt + 1;
            if (gap_len < 2) gap_bad = gap_bad + 1;
            cur_in = in_base;
            cur_w  = w_base;
            cur_r  = r_base;
        end else if (conv_en && (in_base !== cur_in || w_base !== cur_w || r_base !== cur_r)) begin
            base_chg = base_chg + 1;
        end
        if (conv_en) gap_len = 0;
        else if (gap_len < 1000) gap_len = gap_len + 1;
        if (done) begin
            done_cnt = done_cnt + 1;
            if (busy) done_busy_bad = done_busy_bad + 1;
        end
        if (done_wd) done_wd_cnt = done_wd_cnt + 1;
        en_prev = conv_en;
    end

    task automatic pulse_start(input logic [7:0] n, input logic [15:0] si, input logic [15:0] sw,
                               input logic [15:0] sr);
        num_passes = n;
        in_stride  = si;
        w_stride   = sw;
        r_stride   = sr;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_pass(input logic [7:0] p, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (conv_en && pass_idx == p) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({conv_en, busy, done, timeout_err} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 0000", {conv_en, busy, done, timeout_err});
        end
        n_cmp++;
        if ({in_base, w_base, r_base, pass_idx} !== 56'd0) begin
            n_err++;
            $display("FAIL reset_bases: got %h want 0", {in_base, w_base, r_base, pass_idx});
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_passes();
        int w0, d0, g0, b0, db0;
        bit ok;
        logic [15:0] exp_in[3], exp_w[3], exp_r[3];
        exp_in = '{16'd0, 16'd25, 16'd50};
        exp_w  = '{16'd0, 16'd27, 16'd54};
        exp_r  = '{16'd0, 16'd9, 16'd18};
        eng_delay = 40;
        eng_level = 1'b0;
        w0 = win_cnt; d0 = done_cnt; g0 = gap_bad; b0 = base_chg; db0 = done_busy_bad;
        pulse_start(8'd3, 16'd25, 16'd27, 16'd9);
        n_cmp++;
        if ({busy, conv_en} !== 2'b10) begin
            n_err++;
            $display("FAIL t1_setup_state: busy,conv_en got %b want 10", {busy, conv_en});
        end
        @(negedge clk);
        n_cmp++;
        if (conv_en !== 1'b1) begin
            n_err++;
            $display("FAIL t1_en_latency: got %b want 1", conv_en);
        end
        wait_done(600, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL t1_done_seen: got 0 want 1");
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL t1_busy_with_done: got %b want 0", busy);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL t1_done_one_cycle: got %b want 0", done);
        end
        n_cmp++;
        if (win_cnt - w0 != 3) begin
            n_err++;
            $display("FAIL t1_windows: got %0d want 3", win_cnt - w0);
        end
        n_cmp++;
        if (done_cnt - d0 != 1) begin
            n_err++;
            $display("FAIL t1_done_pulses: got %0d want 1", done_cnt - d0);
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({win_in[w0+k], win_w[w0+k], win_r[w0+k], win_p[w0+k]} !==
                {exp_in[k], exp_w[k], exp_r[k], 8'(k)}) begin
                n_err++;
                $display("FAIL t1_bases_pass%0d: got %0d/%0d/%0d idx %0d want %0d/%0d/%0d idx %0d",
                         k, win_in[w0+k], win_w[w0+k], win_r[w0+k], win_p[w0+k],
                         exp_in[k], exp_w[k], exp_r[k], k);
            end
        end
        n_cmp++;
        if ((gap_bad - g0) + (base_chg - b0) + (done_busy_bad - db0) != 0) begin
            n_err++;
            $display("FAIL t1_protocol: gap %0d base_chg %0d done_busy %0d want 0 0 0",
                     gap_bad - g0, base_chg - b0, done_busy_bad - db0);
        end
    endtask

    task automatic test_zero_passes();
        int w0;
        w0 = win_cnt;
        pulse_start(8'd0, 16'd1, 16'd1, 16'd1);
        n_cmp++;
        if ({busy, done} !== 2'b10) begin
            n_err++;
            $display("FAIL t2_after_start: busy,done got %b want 10", {busy, done});
        end
        @(negedge clk);
        n_cmp++;
        if ({busy, done} !== 2'b01) begin
            n_err++;
            $display("FAIL t2_done_pulse: busy,done got %b want 01", {busy, done});
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (done !== 1'b0 || win_cnt != w0) begin
            n_err++;
            $display("FAIL t2_quiet: done %b windows %0d want 0 0", done, win_cnt - w0);
        end
    endtask

    task automatic test_wrap();
        int w0;
        bit ok;
        logic [15:0] exp_in[3];
        exp_in = '{16'h0000, 16'hFFF0, 16'hFFE0};
        eng_delay = 5;
        w0 = win_cnt;
        pulse_start(8'd3, 16'hFFF0, 16'd1, 16'd2);
        wait_done(300, ok);
        #1;
        n_cmp++;
        if (!ok || win_cnt - w0 != 3) begin
            n_err++;
            $display("FAIL t3_run: done %b windows %0d want 1 3", ok, win_cnt - w0);
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({win_in[w0+k], win_r[w0+k]} !== {exp_in[k], 16'(2 * k)}) begin
                n_err++;
                $display("FAIL t3_wrap_pass%0d: in %h r %h want in %h r %h",
                         k, win_in[w0+k], win_r[w0+k], exp_in[k], 16'(2 * k));
            end
        end
    endtask

    task automatic test_timeout();
        int hi, d0;
        bit ok;
        d0 = done_wd_cnt;
        num_passes = 8'd2;
        start_wd = 1'b1;
        @(negedge clk);
        start_wd = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (conv_en_wd) begin
                ok = 1'b1;
                break;
            end
        end
        hi = 0;
        while (ok && conv_en_wd && hi < 100) begin
            hi++;
            @(negedge clk);
        end
        n_cmp++;
        if (hi != 16) begin
            n_err++;
            $display("FAIL t4_run_cycles: got %0d want 16", hi);
        end
        n_cmp++;
        if ({timeout_err_wd, busy_wd, done_wd} !== 3'b100) begin
            n_err++;
            $display("FAIL t4_flags: err,busy,done got %b want 100",
                     {timeout_err_wd, busy_wd, done_wd});
        end
        repeat (3) @(negedge clk);
        abort_wd = 1'b1;
        @(negedge clk);
        abort_wd = 1'b0;
        #1;
        n_cmp++;
        if ({timeout_err_wd, conv_en_wd} !== 2'b10 || done_wd_cnt != d0) begin
            n_err++;
            $display("FAIL t4_sticky: err,en got %b dones %0d want 10 0",
                     {timeout_err_wd, conv_en_wd}, done_wd_cnt - d0);
        end
        start_wd = 1'b1;
        @(negedge clk);
        start_wd = 1'b0;
        n_cmp++;
        if ({timeout_err_wd, busy_wd} !== 2'b01) begin
            n_err++;
            $display("FAIL t4_restart_clears: err,busy got %b want 01",
                     {timeout_err_wd, busy_wd});
        end
        abort_wd = 1'b1;
        @(negedge clk);
        abort_wd = 1'b0;
    endtask

    task automatic test_abort();
        int w0, d0;
        bit ok;
        eng_delay = 10;
        eng_level = 1'b0;
        pulse_start(8'd4, 16'd4, 16'd4, 16'd4);
        wait_pass(8'd1, 200, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL t5_reach_pass1: got 0 want 1");
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        w0 = win_cnt; d0 = done_cnt;
        n_cmp++;
        if ({conv_en, busy, timeout_err} !== 3'b000) begin
            n_err++;
            $display("FAIL t5_abort: en,busy,err got %b want 000", {conv_en, busy, timeout_err});
        end
        repeat (20) @(negedge clk);
        #1;
        n_cmp++;
        if (win_cnt != w0 || done_cnt != d0) begin
            n_err++;
            $display("FAIL t5_after_abort: windows %0d dones %0d want 0 0",
                     win_cnt - w0, done_cnt - d0);
        end
        num_passes = 8'd2;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL t5_start_abort_busy: got %b want 0", busy);
        end
        repeat (5) @(negedge clk);
        #1;
        n_cmp++;
        if (conv_en !== 1'b0 || win_cnt != w0) begin
            n_err++;
            $display("FAIL t5_start_abort_idle: en %b windows %0d want 0 0", conv_en, win_cnt - w0);
        end
    endtask

    task automatic test_level_and_reset();
        int w0, d0;
        bit ok;
        eng_delay = 6;
        eng_level = 1'b1;
        eng_hold  = 3;
        w0 = win_cnt; d0 = done_cnt;
        pulse_start(8'd3, 16'd1, 16'd2, 16'd3);
        ok = 1'b0;
        // Start pulses while busy, with a different config that must not be picked up.
        for (int i = 1; i < 400; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
            start = (i % 7 == 0);
            if (start) begin
                num_passes = 8'd9;
                in_stride  = 16'd100;
                w_stride   = 16'd100;
                r_stride   = 16'd100;
            end
        end
        start = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++;
        if (!ok || win_cnt - w0 != 3 || done_cnt - d0 != 1) begin
            n_err++;
            $display("FAIL t6_level_run: done %b windows %0d dones %0d want 1 3 1",
                     ok, win_cnt - w0, done_cnt - d0);
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({win_in[w0+k], win_w[w0+k], win_r[w0+k]} !==
                {16'(k), 16'(2 * k), 16'(3 * k)}) begin
                n_err++;
                $display("FAIL t6_bases_pass%0d: got %0d/%0d/%0d want %0d/%0d/%0d", k,
                         win_in[w0+k], win_w[w0+k], win_r[w0+k], k, 2 * k, 3 * k);
            end
        end
        eng_level = 1'b0;
        eng_delay = 20;
        pulse_start(8'd5, 16'd7, 16'd7, 16'd7);
        wait_pass(8'd2, 300, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL t6_reach_pass2: got 0 want 1");
        end
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        #1;
        w0 = win_cnt; d0 = done_cnt;
        n_cmp++;
        if ({conv_en, busy, done, timeout_err} !== 4'b0000 ||
            {in_base, w_base, r_base, pass_idx} !== 56'd0) begin
            n_err++;
            $display("FAIL t6_mid_reset: flags %b bases %h want 0 0",
                     {conv_en, busy, done, timeout_err}, {in_base, w_base, r_base, pass_idx});
        end
        repeat (30) @(negedge clk);
        #1;
        n_cmp++;
        if (win_cnt != w0 || done_cnt != d0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL t6_after_reset: windows %0d dones %0d busy %b want 0 0 0",
                     win_cnt - w0, done_cnt - d0, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic_passes();
        test_zero_passes();
        test_wrap();
        test_timeout();
        test_abort();
        test_level_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
